// File: rtl/pwm_window_ctrl.sv
// pwm_window_ctrl: counts high samples of red/green/blue PWM inputs over WIN_LEN-sample windows.
// Define PWM_OVERRUN_EN to let an unconsumed result be overwritten, which sets the sticky overrun flag.
module pwm_window_ctrl #(
   parameter int unsigned WIN_LEN = 32'h0090_0000,
   parameter int          CW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          continuous,
   input  logic          red,
   input  logic          green,
   input  logic          blue,
   input  logic          res_ready,
   output logic          res_valid,
   output logic [CW-1:0] red_cnt,
   output logic [CW-1:0] green_cnt,
   output logic [CW-1:0] blue_cnt,
   output logic [CW-1:0] total_cnt,
   output logic          busy,
   output logic          overrun
);
   typedef enum logic {S_IDLE, S_MEAS} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_t, r_r, r_g, r_b, w_t, w_r, w_g, w_b;
   logic [CW-1:0] r_res_r, r_res_g, r_res_b, r_res_t;
   logic          r_valid, r_busy, w_smp, w_latch, w_hs, w_load;
   always_comb begin
      w_smp   = (r_state == S_MEAS) && !stop;
      w_latch = w_smp && (r_t == CW'(WIN_LEN - 1));
      w_hs    = r_valid && res_ready;
`ifdef PWM_OVERRUN_EN
      w_load  = w_latch;
`else
      w_load  = w_latch && (!r_valid || res_ready);
`endif
      w_t     = r_t + CW'(1);
      w_r     = r_r + CW'(red);
      w_g     = r_g + CW'(green);
      w_b     = r_b + CW'(blue);
      w_next  = (r_state == S_IDLE) ? ((start && !stop) ? S_MEAS : S_IDLE) :
                (stop || (w_latch && !continuous)) ? S_IDLE : S_MEAS;
   end
   // Counters restart from zero on the latch cycle so back-to-back windows lose no sample.
   always_ff @(posedge clk) begin
      r_state <= rst ? S_IDLE : w_next;
      r_busy  <= !rst && (w_next == S_MEAS);
      r_valid <= !rst && (w_load || (r_valid && !w_hs));
      {r_t, r_r, r_g, r_b} <= (rst || !w_smp || w_latch) ? '0 : {w_t, w_r, w_g, w_b};
      if (rst)
         {r_res_t, r_res_r, r_res_g, r_res_b} <= '0;
      else if (w_load)
         {r_res_t, r_res_r, r_res_g, r_res_b} <= {w_t, w_r, w_g, w_b};
   end
`ifdef PWM_OVERRUN_EN
   logic r_ovr;
   always_ff @(posedge clk)
      r_ovr <= !rst && (r_ovr || (w_latch && r_valid && !res_ready));
   assign overrun = r_ovr;
`else
   assign overrun = 1'b0;
`endif
   assign res_valid = r_valid;
   assign busy      = r_busy;
   assign red_cnt   = r_res_r;
   assign green_cnt = r_res_g;
   assign blue_cnt  = r_res_b;
   assign total_cnt = r_res_t;
endmodule

// File: tb/tb_pwm_window_ctrl.sv
// tb_pwm_window_ctrl: random and directed stimulus against a sample-list reference model with a result scoreboard.
module tb_pwm_window_ctrl;
   localparam int WL = 16;
   localparam int CW = 32;
`ifdef PWM_OVERRUN_EN
   localparam bit OVR_EXP = 1'b1;
`else
   localparam bit OVR_EXP = 1'b0;
`endif
   typedef struct packed {
      logic [31:0] r;
      logic [31:0] g;
      logic [31:0] b;
      logic [31:0] t;
   } res_t;
   logic clk = 0, rst = 1, start = 0, stop = 0, continuous = 0;
   logic red = 0, green = 0, blue = 0, res_ready = 0;
   logic res_valid, busy, overrun;
   logic [CW-1:0] red_cnt, green_cnt, blue_cnt, total_cnt;
   int tests = 0, fails = 0;
   logic [2:0] m_smp[$];
   res_t exp_q[$];
   logic m_busy = 0, m_valid = 0, m_ovr = 0;
   always #5 clk = ~clk;
   pwm_window_ctrl #(.WIN_LEN(WL), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
      .red(red), .green(green), .blue(blue), .res_ready(res_ready),
      .res_valid(res_valid), .red_cnt(red_cnt), .green_cnt(green_cnt),
      .blue_cnt(blue_cnt), .total_cnt(total_cnt), .busy(busy), .overrun(overrun)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic rand_rgb();
      {red, green, blue} = 3'($urandom);
   endtask
   task automatic chk_zero();
      chk("rst_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_red", red_cnt, 0);
      chk("rst_green", green_cnt, 0);
      chk("rst_blue", blue_cnt, 0);
      chk("rst_total", total_cnt, 0);
   endtask
   // Reference model: collects a window's samples, then sums them once the window is full.
   always @(posedge clk) begin : model
      res_t nr;
      logic hs, ld;
      nr = '0;
      ld = 0;
      hs = m_valid && res_ready;
      if (rst) begin
         m_busy = 0;
         m_valid = 0;
         m_ovr = 0;
         m_smp.delete();
         exp_q.delete();
      end else begin
         if (m_busy) begin
            if (stop) begin
               m_busy = 0;
               m_smp.delete();
            end else begin
               m_smp.push_back({red, green, blue});
               if (m_smp.size() == WL) begin
                  foreach (m_smp[i]) begin
                     nr.r += 32'(m_smp[i][2]);
                     nr.g += 32'(m_smp[i][1]);
                     nr.b += 32'(m_smp[i][0]);
                  end
                  nr.t = WL;
                  ld = 1;
                  m_smp.delete();
                  m_busy = continuous;
               end
            end
         end else if (start && !stop)
            m_busy = 1;
         if (ld && (!m_valid || hs)) begin
            exp_q.push_back(nr);
            m_valid = 1;
         end else if (ld) begin
`ifdef PWM_OVERRUN_EN
            exp_q[exp_q.size()-1] = nr;
            m_ovr = 1;
`endif
         end else if (hs)
            m_valid = 0;
      end
   end
   always @(negedge clk) begin : monitor
      chk("res_valid", res_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL result: got res_valid=1 expected no pending result at %0t", $time);
         end else begin
            chk("red_cnt", red_cnt, exp_q[0].r);
            chk("green_cnt", green_cnt, exp_q[0].g);
            chk("blue_cnt", blue_cnt, exp_q[0].b);
            chk("total_cnt", total_cnt, exp_q[0].t);
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end
   initial begin
      int n;
      repeat (3) step();
      rst = 0;
      chk_zero();
      red = 1; green = 0; blue = 0; start = 1;
      step();
      start = 0;
      n = 0;
      while (!res_valid && n < 40) begin
         green = ~green;
         step();
         n++;
      end
      chk("latency", n + 1, 17);
      chk("single_red", red_cnt, 16);
      chk("single_green", green_cnt, 8);
      chk("single_blue", blue_cnt, 0);
      chk("single_total", total_cnt, 16);
      chk("single_busy", busy, 0);
      res_ready = 1;
      step();
      res_ready = 0;
      continuous = 1; res_ready = 1; start = 1;
      rand_rgb();
      step();
      start = 0;
      repeat (WL) begin rand_rgb(); step(); end
      for (int i = 0; i < WL; i++) begin
         red = (i == 0); green = 1'($urandom); blue = 1'($urandom);
         step();
      end
      chk("win2_red", red_cnt, 1);
      chk("win2_valid", res_valid, 1);
      for (int i = 0; i < 10; i++) begin rand_rgb(); step(); end
      stop = 1; step(); stop = 0;
      continuous = 0; res_ready = 0;
      repeat (3) step();
      chk("stop_busy", busy, 0);
      continuous = 1; start = 1;
      step();
      start = 0;
      repeat (2 * WL) begin rand_rgb(); step(); end
      stop = 1; step(); stop = 0;
      chk("overrun_flag", overrun, OVR_EXP);
      res_ready = 1; step(); res_ready = 0;
      continuous = 0; start = 1;
      step();
      start = 0;
      repeat (7) begin rand_rgb(); step(); end
      rst = 1; step(); rst = 0;
      chk_zero();
      start = 1; step(); start = 0;
      repeat (WL) begin rand_rgb(); step(); end
      chk("post_rst_total", total_cnt, 16);
      chk("post_rst_valid", res_valid, 1);
      res_ready = 1; step(); res_ready = 0;
      rst = 1; step(); rst = 0;
      continuous = 1; start = 1;
      step();
      start = 0;
      repeat (2 * WL - 1) begin rand_rgb(); step(); end
      res_ready = 1; rand_rgb(); step(); res_ready = 0;
      chk("hs_latch_valid", res_valid, 1);
      chk("hs_latch_overrun", overrun, 0);
      chk("hs_latch_total", total_cnt, 16);
      stop = 1; step(); stop = 0; continuous = 0;
      repeat (1500) begin
         rst = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 7) == 0);
         stop = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) continuous = ~continuous;
         res_ready = ($urandom_range(0, 2) == 0);
         rand_rgb();
         step();
      end
      rst = 0; start = 0; stop = 0;
      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
